// File: rtl/sonic_trigger_scheduler.sv
// Time-multiplexed trigger sequencer for an ultrasonic sensor array: one group at a time
// goes through TRIG, LISTEN and GAP, and sensors whose echo did not complete are flagged.
module sonic_trigger_scheduler #(
  parameter int NUM_SENSORS   = 6,
  parameter int NUM_GROUPS    = 2,
  parameter int TRIG_CYCLES   = 500,
  parameter int LISTEN_CYCLES = 1500000,
  parameter int GAP_CYCLES    = 250000,
  localparam int AGW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_GROUPS-1:0]  group_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [AGW-1:0]         active_group,
  output logic                   busy,
  output logic                   group_done,
  output logic                   round_done,
  output logic [NUM_SENSORS-1:0] timeout_flags,
  output logic [1:0]             state_dbg
);

  localparam int MAXC_TL = (TRIG_CYCLES > LISTEN_CYCLES) ? TRIG_CYCLES : LISTEN_CYCLES;
  localparam int MAXC    = (MAXC_TL > GAP_CYCLES) ? MAXC_TL : GAP_CYCLES;
  localparam int CW      = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, TRIG, LISTEN, GAP} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt;
  logic [AGW-1:0]         group_q, grp_n, first_grp, above_grp, next_grp;
  logic                   first_found, above_found, wrap;
  logic [NUM_SENSORS-1:0] echo_s1, echo_s2, echo_s3;
  logic [NUM_SENSORS-1:0] echo_rise, echo_fall;
  logic [NUM_SENSORS-1:0] seen_rise, seen_fall, seen_fall_n, cur_bits;
  logic                   all_fall, listen_exit;

  function automatic logic [NUM_SENSORS-1:0] grp_bits(input logic [AGW-1:0] g);
    logic [NUM_SENSORS-1:0] m;
    for (int i = 0; i < NUM_SENSORS; i++) m[i] = ((i % NUM_GROUPS) == int'(g));
    return m;
  endfunction

  assign echo_rise   = echo_s2 & ~echo_s3;
  assign echo_fall   = ~echo_s2 & echo_s3;
  assign cur_bits    = grp_bits(group_q);
  // A fall only counts once its rise was seen, so an echo already high on entry never completes.
  assign seen_fall_n = seen_fall | (echo_fall & seen_rise);
  assign all_fall    = &(seen_fall_n | ~cur_bits);
  assign listen_exit = all_fall || (cnt == CW'(LISTEN_CYCLES - 1));

  // Lowest eligible group, and the next eligible group above the current one (wrapping).
  always_comb begin
    first_found = 1'b0;
    first_grp   = '0;
    above_found = 1'b0;
    above_grp   = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (group_mask[g] && !first_found) begin
        first_found = 1'b1;
        first_grp   = AGW'(g);
      end
      if (group_mask[g] && (g > int'(group_q)) && !above_found) begin
        above_found = 1'b1;
        above_grp   = AGW'(g);
      end
    end
    next_grp = above_found ? above_grp : first_grp;
    wrap     = !above_found;
  end

  always_comb begin
    state_n    = state;
    grp_n      = group_q;
    group_done = 1'b0;
    round_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (|group_mask)) begin
          state_n = TRIG;
          grp_n   = first_grp;
        end
      end
      TRIG: begin
        if (cnt == CW'(TRIG_CYCLES - 1)) state_n = LISTEN;
      end
      LISTEN: begin
        if (listen_exit) begin
          state_n    = GAP;
          group_done = 1'b1;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          if (!enable || !(|group_mask)) begin
            state_n    = IDLE;
            round_done = 1'b1;
          end else begin
            state_n    = TRIG;
            grp_n      = next_grp;
            round_done = wrap;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt           <= '0;
      group_q       <= '0;
      trig          <= '0;
      echo_s1       <= '0;
      echo_s2       <= '0;
      echo_s3       <= '0;
      seen_rise     <= '0;
      seen_fall     <= '0;
      timeout_flags <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
      group_q <= grp_n;
      trig    <= (state_n == TRIG) ? grp_bits(grp_n) : '0;
      if ((state_n != state) || (state == IDLE)) cnt <= '0;
      else                                       cnt <= cnt + 1'b1;
      if ((state == TRIG) && (state_n == LISTEN)) begin
        seen_rise <= '0;
        seen_fall <= '0;
      end else if (state == LISTEN) begin
        seen_rise <= seen_rise | echo_rise;
        seen_fall <= seen_fall_n;
      end
      if (group_done)
        timeout_flags <= (timeout_flags & ~cur_bits) | (~seen_fall_n & cur_bits);
    end
  end

  assign active_group = group_q;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_sonic_trigger_scheduler.sv
// Directed bench for sonic_trigger_scheduler with short trigger/listen/gap windows.
module tb_sonic_trigger_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] group_mask = 2'b00;
  logic [5:0] echo = 6'b0;
  logic [5:0] trig;
  logic [0:0] active_group;
  logic       busy, group_done, round_done;
  logic [5:0] timeout_flags;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  sonic_trigger_scheduler #(
    .NUM_SENSORS(6), .NUM_GROUPS(2), .TRIG_CYCLES(4), .LISTEN_CYCLES(20), .GAP_CYCLES(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .group_mask(group_mask),
    .echo(echo), .trig(trig), .active_group(active_group), .busy(busy),
    .group_done(group_done), .round_done(round_done), .timeout_flags(timeout_flags),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; group_mask = 2'b00; echo = 6'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Driver helpers
  task automatic wait_for_trig(input logic [5:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (trig === want) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic count_width(input logic [5:0] want, output int w);
    w = 0;
    while (trig === want && w < 50) begin
      w++;
      tick();
    end
  endtask

  // Starts at the first LISTEN cycle (k=0); returns the k on which group_done is seen.
  task automatic run_listen(input int set_k, input logic [5:0] set_val, input int clr_k,
                            input logic [5:0] clr_val, input int en_off_k, output int done_at);
    done_at = -1;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      if (k == set_k) echo = set_val;
      if (k == clr_k) echo = clr_val;
      if (k == en_off_k) enable = 1'b0;
      if (group_done === 1'b1) done_at = k;
      else tick();
    end
  endtask

  // Tests
  task automatic test_reset();
    do_reset();
    checks++; if (trig !== 6'b0) begin errors++; $display("FAIL reset_trig: got %b expected %b", trig, 6'b0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (active_group !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active_group); end
    checks++; if (timeout_flags !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected %b", timeout_flags, 6'b0); end
    checks++; if (group_done !== 1'b0 || round_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: got gd=%b rd=%b expected 0 0", group_done, round_done); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_timeout_round();
    bit ok; int w; int done_at;
    enable = 1'b1; group_mask = 2'b11;
    wait_for_trig(6'b010101, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_trig0_seen: got %b expected %b", trig, 6'b010101); end
    count_width(6'b010101, w);
    checks++; if (w !== 4) begin errors++; $display("FAIL t1_trig0_width: got %0d expected 4", w); end
    run_listen(-1, 6'b0, -1, 6'b0, -1, done_at);
    checks++; if (done_at !== 19) begin errors++; $display("FAIL t1_listen_len: got %0d expected 19", done_at); end
    tick();
    checks++; if (timeout_flags !== 6'b010101) begin errors++; $display("FAIL t1_flags: got %b expected %b", timeout_flags, 6'b010101); end
    checks++; if (trig !== 6'b0 || busy !== 1'b1) begin errors++; $display("FAIL t1_gap: got trig=%b busy=%b expected 000000 1", trig, busy); end
    tick(); tick();
    checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL t1_no_wrap: got %b expected 0", round_done); end
    tick();
    checks++; if (trig !== 6'b101010 || active_group !== 1'b1) begin errors++; $display("FAIL t1_trig1: got trig=%b ag=%b expected 101010 1", trig, active_group); end
    count_width(6'b101010, w);
    checks++; if (w !== 4) begin errors++; $display("FAIL t1_trig1_width: got %0d expected 4", w); end
  endtask

  task automatic test_early_complete();
    bit ok; int w; int done_at; int pulses;
    wait_for_trig(6'b010101, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_trig0_seen: got %b expected %b", trig, 6'b010101); end
    count_width(6'b010101, w);
    run_listen(2, 6'b010101, 7, 6'b000000, -1, done_at);
    checks++; if (done_at !== 9) begin errors++; $display("FAIL t2_listen_len: got %0d expected 9", done_at); end
    pulses = (group_done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (timeout_flags !== 6'b101010) begin errors++; $display("FAIL t2_flags: got %b expected %b", timeout_flags, 6'b101010); end
      end
      if (group_done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL t2_done_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_stuck_echo();
    bit ok; int w; int done_at;
    echo = 6'b000100;
    wait_for_trig(6'b010101, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_trig0_seen: got %b expected %b", trig, 6'b010101); end
    count_width(6'b010101, w);
    run_listen(2, 6'b010101, 7, 6'b000100, -1, done_at);
    checks++; if (done_at !== 19) begin errors++; $display("FAIL t3_listen_len: got %0d expected 19", done_at); end
    tick();
    checks++; if (timeout_flags !== 6'b101110) begin errors++; $display("FAIL t3_flags: got %b expected %b", timeout_flags, 6'b101110); end
    echo = 6'b0;
  endtask

  task automatic test_single_group();
    int rd; int onsets; int bad_trig; int bad_grp; int gd; int rd1; int rd2;
    logic [5:0] prev_trig;
    do_reset();
    enable = 1'b1; group_mask = 2'b10;
    rd = 0; onsets = 0; bad_trig = 0; bad_grp = 0; gd = 0; rd1 = -1; rd2 = -1; prev_trig = 6'b0;
    for (int c = 0; c < 200 && rd < 3; c++) begin
      tick();
      if ((trig & 6'b010101) != 6'b0) bad_trig++;
      if (trig === 6'b101010 && prev_trig === 6'b0) onsets++;
      if (busy && active_group !== 1'b1) bad_grp++;
      if (group_done === 1'b1) gd++;
      if (round_done === 1'b1) begin
        rd++;
        if (rd == 1) rd1 = c;
        if (rd == 2) rd2 = c;
      end
      prev_trig = trig;
    end
    checks++; if (rd !== 3) begin errors++; $display("FAIL t4_round_count: got %0d expected 3", rd); end
    checks++; if (onsets !== 3) begin errors++; $display("FAIL t4_trig_onsets: got %0d expected 3", onsets); end
    checks++; if (gd !== 3) begin errors++; $display("FAIL t4_group_done: got %0d expected 3", gd); end
    checks++; if (bad_trig !== 0) begin errors++; $display("FAIL t4_group0_trig: got %0d expected 0", bad_trig); end
    checks++; if (bad_grp !== 0) begin errors++; $display("FAIL t4_active_group: got %0d expected 0", bad_grp); end
    checks++; if (rd2 - rd1 !== 27) begin errors++; $display("FAIL t4_round_period: got %0d expected 27", rd2 - rd1); end
  endtask

  task automatic test_enable_drop();
    bit ok; int w; int done_at; int rd_early; int bad;
    do_reset();
    enable = 1'b1; group_mask = 2'b11;
    wait_for_trig(6'b010101, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_trig0_seen: got %b expected %b", trig, 6'b010101); end
    count_width(6'b010101, w);
    run_listen(-1, 6'b0, -1, 6'b0, 5, done_at);
    checks++; if (done_at !== 19) begin errors++; $display("FAIL t5_listen_len: got %0d expected 19", done_at); end
    rd_early = 0;
    tick(); if (round_done === 1'b1) rd_early++;
    tick(); if (round_done === 1'b1) rd_early++;
    tick();
    checks++; if (round_done !== 1'b1 || rd_early !== 0) begin errors++; $display("FAIL t5_round_done: got end=%b early=%0d expected 1 0", round_done, rd_early); end
    tick();
    checks++; if (busy !== 1'b0 || trig !== 6'b0) begin errors++; $display("FAIL t5_idle: got busy=%b trig=%b expected 0 000000", busy, trig); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (trig !== 6'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t5_stays_idle: got %0d active cycles expected 0", bad); end
    checks++; if (timeout_flags !== 6'b010101) begin errors++; $display("FAIL t5_flags: got %b expected %b", timeout_flags, 6'b010101); end
  endtask

  task automatic test_reset_mid_trig();
    bit ok;
    do_reset();
    enable = 1'b1; group_mask = 2'b11;
    wait_for_trig(6'b101010, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_trig1_seen: got %b expected %b", trig, 6'b101010); end
    checks++; if (timeout_flags !== 6'b010101) begin errors++; $display("FAIL t6_flags_pre: got %b expected %b", timeout_flags, 6'b010101); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (trig !== 6'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_reset_drop: got trig=%b busy=%b expected 000000 0", trig, busy); end
    checks++; if (timeout_flags !== 6'b0 || active_group !== 1'b0) begin errors++; $display("FAIL t6_reset_clear: got flags=%b ag=%b expected 000000 0", timeout_flags, active_group); end
    reset = 1'b0;
    tick();
    checks++; if (trig !== 6'b010101 || active_group !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t6_restart: got trig=%b ag=%b busy=%b expected 010101 0 1", trig, active_group, busy); end
  endtask

  initial begin
    test_reset();
    test_timeout_round();
    test_early_complete();
    test_stuck_echo();
    test_single_group();
    test_enable_drop();
    test_reset_mid_trig();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_trigger_scheduler.md
Name: sonic_trigger_scheduler

Overview:
Sequences the trigger lines of the ultrasonic sensor array in time-multiplexed groups, so that sensors in different groups never ping at the same time. For each group it issues one trigger pulse, then listens for echo completion or timeout, then waits a guard gap before moving to the next group. It sits between the top-level sensor network and the per-sensor distance measurement blocks, and it replaces any free-running trigger generator. It also reports which group is active, and flags sensors whose echoes time out.

Parameters:
NUM_SENSORS, 6, number of sensor channels; sensor i belongs to group (i mod NUM_GROUPS)
NUM_GROUPS, 2, number of trigger groups (1..NUM_SENSORS)
TRIG_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz)
LISTEN_CYCLES, 1500000, maximum listen window per group in clocks (30 ms)
GAP_CYCLES, 250000, guard time after listen before the next group, in clocks (5 ms)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run scheduling; low = finish current group then idle
group_mask  in  NUM_GROUPS  1 = group eligible for scheduling
echo  in  NUM_SENSORS  raw asynchronous echo inputs
trig  out  NUM_SENSORS  trigger outputs, registered
active_group  out  clog2(NUM_GROUPS) (min 1)  index of the group currently in TRIG/LISTEN/GAP
busy  out  1  high in any state except IDLE
group_done  out  1  one-cycle pulse on the last LISTEN cycle
round_done  out  1  one-cycle pulse when scheduling wraps or stops
timeout_flags  out  NUM_SENSORS  per-sensor flag: 1 = last measurement incomplete

Behaviour:
- Reset (synchronous): state IDLE; trig=0, active_group=0, busy=0, group_done=0, round_done=0, timeout_flags=0; synchronizers and counters cleared. Reset asserted mid-operation drops trig on the next edge.
- Echo inputs pass through a 2-flop synchronizer (2 cycles latency), then an edge detector against the previous synchronized value.
- States: IDLE, TRIG, LISTEN, GAP.
- IDLE: when enable=1 and group_mask!=0, the next state is TRIG for the lowest-index set group. A zero mask holds IDLE.
- TRIG: trig[i]=1 for all sensors of active_group for exactly TRIG_CYCLES cycles; all other trig bits stay 0. Then go to LISTEN.
- LISTEN: per-sensor seen_rise and seen_fall bits are cleared on entry. A rising edge sets seen_rise. A falling edge sets seen_fall only if seen_rise is already set, so an echo already high on entry does not count as a rise.
- LISTEN exits after the cycle in which every group sensor has seen_fall=1, or after LISTEN_CYCLES cycles, whichever comes first. group_done pulses on that exit cycle.
- On LISTEN exit, timeout_flags[i] for each sensor of the group is set to ~seen_fall[i]. Flags of other groups hold their values.
- GAP: lasts GAP_CYCLES cycles, with trig=0.
- At the end of GAP, the next group is the next set bit of group_mask above active_group, wrapping modulo NUM_GROUPS. group_mask is sampled only at this point (and in IDLE).
- round_done pulses at the end of GAP when any of these holds: the next index ≤ current index (wrap), enable=0, or group_mask=0. In the last two cases the state goes to IDLE.
- enable deassertion never truncates TRIG, LISTEN or GAP.
- A single enabled group re-triggers itself after every GAP, and round_done pulses on each such GAP end.
- Counters are wide enough for max(TRIG_CYCLES, LISTEN_CYCLES, GAP_CYCLES). Counter width is clog2 of that value, plus 1 bit.
- active_group changes only on the IDLE->TRIG or GAP->TRIG transition.

Test Plan:
(Parameters: NUM_SENSORS=6, NUM_GROUPS=2, TRIG_CYCLES=4, LISTEN_CYCLES=20, GAP_CYCLES=3.)
1. Reset, enable=1, mask=2'b11, echoes held low -> trig=6'b010101 for exactly 4 cycles. Then 20 LISTEN cycles, group_done pulses, timeout_flags=6'b010101. After 3 GAP cycles, trig=6'b101010 for 4 cycles.
2. Group 0 active; echo[0,2,4] rise 3 cycles into LISTEN and fall 5 cycles later -> LISTEN ends early, about 10 cycles after entry (including 2-cycle synchronizer latency). timeout bits 0,2,4 are cleared, and group_done pulses once.
3. echo[2] held high from before TRIG and never falls; echo[0,4] complete normally -> LISTEN runs the full 20 cycles, and timeout_flags[2]=1, timeout_flags[0]=0, timeout_flags[4]=0.
4. mask=2'b10 with enable=1 -> only trig[1,3,5] ever pulse. round_done pulses at every GAP end, and active_group stays at 1.
5. enable dropped mid-LISTEN of group 0 -> LISTEN and GAP complete, round_done pulses, the block goes to IDLE with busy=0, and group 1 is never triggered.
6. reset asserted during TRIG -> trig=0 and busy=0 on the next edge, and timeout_flags=0. Release with enable=1 -> the sequence restarts at group 0.
